// File: rtl/block_pingpong_buffer.sv
// Multi-bank ring block buffer: a streaming producer fills banks in order while a
// random-access consumer reads the oldest completed bank and then releases it.
module block_pingpong_buffer #(
    parameter int NUM_BANKS  = 2,
    parameter int BLOCK_SIZE = 256,
    parameter int DATA_WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          wr_last,
    output logic                          rd_bank_valid,
    output logic [$clog2(BLOCK_SIZE):0]   rd_len,
    input  logic                          rd_en,
    input  logic [$clog2(BLOCK_SIZE)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_data_valid,
    output logic                          rd_oob,
    input  logic                          rd_release,
    output logic [$clog2(NUM_BANKS):0]    banks_full
);

    localparam int AW = $clog2(BLOCK_SIZE);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(NUM_BANKS);
    localparam int FW = BW + 1;

    logic [BW-1:0]         wr_bank_r;
    logic [BW-1:0]         rd_bank_r;
    logic [AW-1:0]         wr_ptr_r;
    logic [LW-1:0]         len_r [NUM_BANKS];
    logic [FW-1:0]         full_r;
    logic                  wr_ready_r;
    logic                  bank_valid_r;
    logic [DATA_WIDTH-1:0] rd_data_r;
    logic                  rd_data_valid_r;
    logic                  rd_oob_r;

    // Banks are laid out back to back; BLOCK_SIZE is a power of two so {bank, word} is the index.
    logic [DATA_WIDTH-1:0] mem [NUM_BANKS*BLOCK_SIZE];

    logic          accept_s;
    logic          complete_s;
    logic          release_s;
    logic          read_s;
    logic [FW-1:0] full_next_s;
    logic [LW-1:0] head_len_s;

    function automatic logic [BW-1:0] next_bank(input logic [BW-1:0] b);
        return (b == BW'(NUM_BANKS - 1)) ? {BW{1'b0}} : b + BW'(1);
    endfunction

    // Handshake decode and next occupancy count.
    always_comb begin
        accept_s    = wr_valid && wr_ready_r;
        complete_s  = accept_s && (wr_last || (wr_ptr_r == AW'(BLOCK_SIZE - 1)));
        release_s   = rd_release && bank_valid_r;
        read_s      = rd_en && bank_valid_r;
        head_len_s  = len_r[rd_bank_r];
        full_next_s = full_r;
        case ({complete_s, release_s})
            2'b10:   full_next_s = full_r + FW'(1);
            2'b01:   full_next_s = full_r - FW'(1);
            default: full_next_s = full_r;
        endcase
    end

    // Producer/consumer pointers, block lengths and occupancy flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_r    <= {BW{1'b0}};
            rd_bank_r    <= {BW{1'b0}};
            wr_ptr_r     <= {AW{1'b0}};
            full_r       <= {FW{1'b0}};
            wr_ready_r   <= 1'b1;
            bank_valid_r <= 1'b0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                len_r[i] <= {LW{1'b0}};
            end
        end else begin
            full_r       <= full_next_s;
            // Flags are precomputed from the next count so they leave the block registered.
            wr_ready_r   <= (full_next_s < FW'(NUM_BANKS));
            bank_valid_r <= (full_next_s != {FW{1'b0}});
            if (release_s) begin
                rd_bank_r <= next_bank(rd_bank_r);
            end
            if (complete_s) begin
                len_r[wr_bank_r] <= {1'b0, wr_ptr_r} + LW'(1);
                wr_ptr_r         <= {AW{1'b0}};
                wr_bank_r        <= next_bank(wr_bank_r);
            end else if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
        end
    end

    // Storage array, deliberately without reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem[{wr_bank_r, wr_ptr_r}] <= wr_data;
        end
    end

    // Registered read port; data holds when no read is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r       <= {DATA_WIDTH{1'b0}};
            rd_data_valid_r <= 1'b0;
            rd_oob_r        <= 1'b0;
        end else begin
            rd_data_valid_r <= read_s;
            if (read_s) begin
                rd_data_r <= mem[{rd_bank_r, rd_addr}];
                rd_oob_r  <= ({1'b0, rd_addr} >= head_len_s);
            end else begin
                rd_oob_r  <= 1'b0;
            end
        end
    end

    assign wr_ready      = wr_ready_r;
    assign rd_bank_valid = bank_valid_r;
    assign rd_len        = bank_valid_r ? head_len_s : {LW{1'b0}};
    assign banks_full    = full_r;
    assign rd_data       = rd_data_r;
    assign rd_data_valid = rd_data_valid_r;
    assign rd_oob        = rd_oob_r;

endmodule

// File: tb/tb_block_pingpong_buffer.sv
// Self-checking bench for block_pingpong_buffer: directed scenarios plus a random
// soak, all compared against a queue-based block model.
module tb_block_pingpong_buffer;

    localparam int NB = 2;
    localparam int BS = 256;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          wr_last = 1'b0;
    logic          rd_bank_valid;
    logic [8:0]    rd_len;
    logic          rd_en = 1'b0;
    logic [7:0]    rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_data_valid;
    logic          rd_oob;
    logic          rd_release = 1'b0;
    logic [1:0]    banks_full;

    int checks = 0;
    int errors = 0;

    // Reference model: completed blocks are a FIFO of bank ids; storage persists over reset.
    int            head_q[$];
    int            m_wb, m_wp;
    logic [DW-1:0] m_mem [NB][BS];
    bit            m_known [NB][BS];
    int            m_len [NB];
    logic [DW-1:0] m_rd_data;
    bit            m_rd_known;
    bit            m_rd_valid;
    bit            m_oob;

    block_pingpong_buffer #(.NUM_BANKS(NB), .BLOCK_SIZE(BS), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
        .rd_bank_valid(rd_bank_valid), .rd_len(rd_len),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_data_valid(rd_data_valid), .rd_oob(rd_oob),
        .rd_release(rd_release), .banks_full(banks_full)
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        head_q.delete();
        m_wb = 0; m_wp = 0;
        for (int b = 0; b < NB; b++) m_len[b] = 0;
        m_rd_data = '0; m_rd_known = 1'b1; m_rd_valid = 1'b0; m_oob = 1'b0;
    endtask

    // Apply current inputs to the model, then advance one clock.
    task automatic cycle();
        bit acc, rd, rel;
        int rb;
        acc = wr_valid && (head_q.size() < NB);
        rd  = rd_en && (head_q.size() != 0);
        rel = rd_release && (head_q.size() != 0);
        m_rd_valid = rd;
        m_oob = 1'b0;
        if (rd) begin
            rb = head_q[0];
            m_oob = (int'(rd_addr) >= m_len[rb]);
            m_rd_known = m_known[rb][rd_addr];
            m_rd_data = m_mem[rb][rd_addr];
        end
        if (rel) void'(head_q.pop_front());
        if (acc) begin
            m_mem[m_wb][m_wp] = wr_data;
            m_known[m_wb][m_wp] = 1'b1;
            if (wr_last || m_wp == BS - 1) begin
                m_len[m_wb] = m_wp + 1;
                head_q.push_back(m_wb);
                m_wb = (m_wb + 1) % NB;
                m_wp = 0;
            end else begin
                m_wp++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d, input bit last);
        wr_valid = 1'b1; wr_data = d; wr_last = last;
        cycle();
        wr_valid = 1'b0; wr_last = 1'b0;
    endtask

    task automatic do_reset();
        wr_valid = 1'b0; wr_last = 1'b0; rd_en = 1'b0; rd_release = 1'b0;
        rst_n = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (wr_ready !== 1'b1 || rd_bank_valid !== 1'b0 || banks_full !== 2'd0 ||
            rd_data !== 64'd0 || rd_data_valid !== 1'b0 || rd_oob !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b bv=%b full=%0d data=%h dv=%b oob=%b, want 1 0 0 0 0 0",
                     wr_ready, rd_bank_valid, banks_full, rd_data, rd_data_valid, rd_oob);
        end
    endtask

    task automatic test_full_block();
        int addrs[3] = '{0, 17, 255};
        do_reset();
        for (int i = 0; i < BS; i++) push(64'(i), 1'b0);
        checks++;
        if (banks_full !== 2'd1 || rd_bank_valid !== 1'b1 || rd_len !== 9'd256 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_block_state: got full=%0d bv=%b len=%0d rdy=%b, want 1 1 256 1",
                     banks_full, rd_bank_valid, rd_len, wr_ready);
        end
        rd_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rd_addr = 8'(addrs[k]);
            cycle();
            checks++;
            if (rd_data_valid !== 1'b1 || rd_data !== 64'(addrs[k]) || rd_oob !== 1'b0) begin
                errors++;
                $display("FAIL full_block_read: addr=%0d got dv=%b data=%0d oob=%b, want 1 %0d 0",
                         addrs[k], rd_data_valid, rd_data, rd_oob, addrs[k]);
            end
        end
        rd_en = 1'b0;
        rd_release = 1'b1; cycle(); rd_release = 1'b0;
    endtask

    task automatic test_short_block();
        logic [DW-1:0] d[5];
        for (int i = 0; i < 5; i++) begin
            d[i] = {$urandom, $urandom};
            push(d[i], i == 4);
        end
        checks++;
        if (rd_len !== 9'd5 || banks_full !== 2'd1) begin
            errors++;
            $display("FAIL short_len: got len=%0d full=%0d, want 5 1", rd_len, banks_full);
        end
        rd_en = 1'b1; rd_addr = 8'd4; cycle();
        checks++;
        if (rd_data_valid !== 1'b1 || rd_data !== d[4] || rd_oob !== 1'b0) begin
            errors++;
            $display("FAIL short_last_word: got dv=%b data=%h oob=%b, want 1 %h 0", rd_data_valid, rd_data, rd_oob, d[4]);
        end
        rd_addr = 8'd5; cycle(); rd_en = 1'b0;
        checks++;
        if (rd_data_valid !== 1'b1 || rd_oob !== 1'b1) begin
            errors++;
            $display("FAIL short_oob: got dv=%b oob=%b, want 1 1", rd_data_valid, rd_oob);
        end
        cycle();
        checks++;
        if (rd_oob !== 1'b0 || rd_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL oob_pulse: got dv=%b oob=%b, want 0 0", rd_data_valid, rd_oob);
        end
        rd_release = 1'b1; cycle(); rd_release = 1'b0;
    endtask

    task automatic test_full_stall();
        logic [DW-1:0] held;
        do_reset();
        for (int i = 0; i < 3; i++) push({$urandom, $urandom}, i == 2);
        for (int i = 0; i < 2; i++) push({$urandom, $urandom}, i == 1);
        checks++;
        if (banks_full !== 2'd2 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_full: got full=%0d rdy=%b, want 2 0", banks_full, wr_ready);
        end
        held = {$urandom, $urandom};
        wr_valid = 1'b1; wr_data = held; wr_last = 1'b1; rd_release = 1'b1;
        cycle();
        rd_release = 1'b0;
        checks++;
        if (wr_ready !== 1'b1 || banks_full !== 2'd1) begin
            errors++;
            $display("FAIL stall_release: got rdy=%b full=%0d, want 1 1", wr_ready, banks_full);
        end
        cycle();
        wr_valid = 1'b0; wr_last = 1'b0;
        checks++;
        if (banks_full !== 2'd2 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_refill: got full=%0d rdy=%b, want 2 0", banks_full, wr_ready);
        end
        rd_release = 1'b1; cycle(); rd_release = 1'b0;
        rd_en = 1'b1; rd_addr = 8'd0;
        checks++;
        if (rd_len !== 9'd1) begin
            errors++;
            $display("FAIL stall_held_len: got len=%0d, want 1", rd_len);
        end
        cycle(); rd_en = 1'b0;
        checks++;
        if (rd_data !== held || rd_data_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_held_word: got data=%h dv=%b, want %h 1", rd_data, rd_data_valid, held);
        end
    endtask

    task automatic test_complete_release();
        logic [DW-1:0] e;
        do_reset();
        push({$urandom, $urandom}, 1'b0);
        push({$urandom, $urandom}, 1'b1);
        e = {$urandom, $urandom};
        wr_valid = 1'b1; wr_data = e; wr_last = 1'b1; rd_release = 1'b1;
        cycle();
        wr_valid = 1'b0; wr_last = 1'b0; rd_release = 1'b0;
        checks++;
        if (banks_full !== 2'd1 || rd_len !== 9'd1 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL complete_release: got full=%0d len=%0d rdy=%b, want 1 1 1", banks_full, rd_len, wr_ready);
        end
        rd_en = 1'b1; rd_addr = 8'd0; cycle(); rd_en = 1'b0;
        checks++;
        if (rd_data !== e) begin
            errors++;
            $display("FAIL complete_release_head: got data=%h, want %h", rd_data, e);
        end
        rd_release = 1'b1; cycle(); rd_release = 1'b0;
    endtask

    task automatic test_read_release();
        logic [DW-1:0] a[3];
        logic [DW-1:0] b[4];
        do_reset();
        for (int i = 0; i < 3; i++) begin a[i] = {$urandom, $urandom}; push(a[i], i == 2); end
        for (int i = 0; i < 4; i++) begin b[i] = {$urandom, $urandom}; push(b[i], i == 3); end
        rd_en = 1'b1; rd_addr = 8'd1; rd_release = 1'b1;
        cycle();
        rd_release = 1'b0;
        checks++;
        if (rd_data !== a[1] || rd_data_valid !== 1'b1 || banks_full !== 2'd1 || rd_len !== 9'd4) begin
            errors++;
            $display("FAIL read_with_release: got data=%h dv=%b full=%0d len=%0d, want %h 1 1 4",
                     rd_data, rd_data_valid, banks_full, rd_len, a[1]);
        end
        cycle();
        rd_en = 1'b0;
        checks++;
        if (rd_data !== b[1]) begin
            errors++;
            $display("FAIL read_next_bank: got data=%h, want %h", rd_data, b[1]);
        end
        rd_release = 1'b1; cycle();
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0; rd_release = 1'b0;
        checks++;
        if (rd_data_valid !== 1'b0 || banks_full !== 2'd0 || rd_bank_valid !== 1'b0 ||
            rd_data !== b[1] || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL empty_read_release: got dv=%b full=%0d bv=%b data=%h rdy=%b, want 0 0 0 %h 1",
                     rd_data_valid, banks_full, rd_bank_valid, rd_data, wr_ready, b[1]);
        end
    endtask

    task automatic test_reset_midblock();
        logic [DW-1:0] f;
        do_reset();
        push({$urandom, $urandom}, 1'b1);
        rd_en = 1'b1; rd_addr = 8'd0; cycle(); rd_en = 1'b0;
        for (int i = 0; i < 3; i++) push({$urandom, $urandom}, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (wr_ready !== 1'b1 || rd_bank_valid !== 1'b0 || banks_full !== 2'd0 ||
            rd_data !== 64'd0 || rd_data_valid !== 1'b0 || rd_oob !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got rdy=%b bv=%b full=%0d data=%h dv=%b oob=%b, want 1 0 0 0 0 0",
                     wr_ready, rd_bank_valid, banks_full, rd_data, rd_data_valid, rd_oob);
        end
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        f = {$urandom, $urandom};
        push(f, 1'b1);
        checks++;
        if (banks_full !== 2'd1 || rd_len !== 9'd1) begin
            errors++;
            $display("FAIL post_reset_block: got full=%0d len=%0d, want 1 1", banks_full, rd_len);
        end
        rd_en = 1'b1; rd_addr = 8'd0; cycle(); rd_en = 1'b0;
        checks++;
        if (rd_data !== f) begin
            errors++;
            $display("FAIL post_reset_word: got data=%h, want %h", rd_data, f);
        end
    endtask

    task automatic test_random();
        int exp_len;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            wr_valid   = ($urandom_range(0, 3) != 0);
            wr_data    = {$urandom, $urandom};
            wr_last    = ($urandom_range(0, 15) == 0);
            rd_en      = ($urandom_range(0, 1) != 0);
            rd_release = ($urandom_range(0, 5) == 0);
            if (head_q.size() != 0 && $urandom_range(0, 3) != 0)
                rd_addr = 8'($urandom_range(0, m_len[head_q[0]] - 1));
            else
                rd_addr = 8'($urandom_range(0, 255));
            exp_len = (head_q.size() != 0) ? m_len[head_q[0]] : 0;
            checks++;
            if (wr_ready !== (head_q.size() < NB) || rd_bank_valid !== (head_q.size() != 0) ||
                banks_full !== 2'(head_q.size()) || (head_q.size() != 0 && rd_len !== 9'(exp_len))) begin
                errors++;
                $display("FAIL rand_state cyc=%0d: got rdy=%b bv=%b full=%0d len=%0d, want full=%0d len=%0d",
                         n, wr_ready, rd_bank_valid, banks_full, rd_len, head_q.size(), exp_len);
            end
            cycle();
            checks++;
            if (rd_data_valid !== m_rd_valid || rd_oob !== m_oob || (m_rd_known && rd_data !== m_rd_data)) begin
                errors++;
                $display("FAIL rand_read cyc=%0d: got dv=%b oob=%b data=%h, want %b %b %h",
                         n, rd_data_valid, rd_oob, rd_data, m_rd_valid, m_oob, m_rd_data);
            end
        end
        wr_valid = 1'b0; rd_en = 1'b0; rd_release = 1'b0; wr_last = 1'b0;
    endtask

    initial begin
        m_reset();
        test_reset();
        test_full_block();
        test_short_block();
        test_full_stall();
        test_complete_release();
        test_read_release();
        test_reset_midblock();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/block_pingpong_buffer.md
Name: block_pingpong_buffer

Overview:
A multi-bank block buffer that decouples a streaming producer from a random-access consumer in the precision core. The producer fills banks in ring order, one block at a time, over a valid/ready stream. The consumer reads any word of the oldest completed bank with registered read latency, then releases the bank back to the producer. It generalises the single-bank synchronous-read buffer with bank count, variable block length, flow control and occupancy tracking.

Parameters:
NUM_BANKS, 2, number of block banks in the ring (>=2).
BLOCK_SIZE, 256, maximum words per block (power of two, >=2).
DATA_WIDTH, 64, word width in bits.

Ports:
clk  input  1  clock, all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
wr_valid  input  1  producer word valid.
wr_ready  output  1  buffer can accept a word.
wr_data  input  DATA_WIDTH  producer word.
wr_last  input  1  word is the final word of the current block.
rd_bank_valid  output  1  at least one completed bank is available to the consumer.
rd_len  output  $clog2(BLOCK_SIZE)+1  word count of the head completed bank.
rd_en  input  1  read request.
rd_addr  input  $clog2(BLOCK_SIZE)  word index within the head bank.
rd_data  output  DATA_WIDTH  registered read data.
rd_data_valid  output  1  rd_data holds the result of a read issued on the previous cycle.
rd_oob  output  1  pulses with rd_data_valid when that read's rd_addr was >= rd_len.
rd_release  input  1  consumer is done with the head bank.
banks_full  output  $clog2(NUM_BANKS)+1  count of completed, unreleased banks.

Behaviour:
- Reset (async assert, sync deassert use): wr_bank=0, wr_ptr=0, rd_bank=0, banks_full=0, rd_data=0, rd_data_valid=0, rd_oob=0. All len[] entries reset to 0. Memory contents are not reset.
- wr_ready = (banks_full < NUM_BANKS), driven from registered state only. There is no same-cycle bypass from rd_release.
- Write accept = wr_valid && wr_ready. On accept, write mem[wr_bank][wr_ptr] = wr_data.
- Block completes on accept when wr_last=1 or wr_ptr==BLOCK_SIZE-1. On completion:
  - len[wr_bank] = wr_ptr+1.
  - wr_ptr returns to 0.
  - wr_bank advances modulo NUM_BANKS.
  - banks_full increments.
- Otherwise wr_ptr increments. wr_valid while wr_ready=0 has no effect; the producer holds its data.
- rd_bank_valid = (banks_full != 0). rd_len = len[rd_bank]. rd_len is 0 (don't-care) when rd_bank_valid=0.
- Read: if rd_en && rd_bank_valid, then on the next edge:
  - rd_data = mem[rd_bank][rd_addr].
  - rd_data_valid = 1.
  - rd_oob = (rd_addr >= rd_len).
  - Latency is 1 cycle, and back-to-back reads are allowed every cycle.
- If rd_en=1 with rd_bank_valid=0: no read, rd_data_valid=0, and rd_data holds its last value.
- An out-of-range read returns stale memory contents and asserts rd_oob. This is not fatal.
- Release: rd_release && rd_bank_valid advances rd_bank modulo NUM_BANKS and decrements banks_full. rd_release while rd_bank_valid=0 is ignored.
- rd_en and rd_release in the same cycle: the read uses the pre-release rd_bank, and its data returns normally next cycle.
- Block completion and release in the same cycle: banks_full is unchanged, and both pointers advance.
- The producer never writes a completed bank, so a read and a write never target the same bank. No read-during-write hazard exists.
- banks_full==NUM_BANKS stalls the producer. wr_ready rises the cycle after a release.
- Reset mid-block discards the partial block and all completed blocks.

Test Plan:
- Reset, then stream 256 words 0..255 without wr_last, NUM_BANKS=2 -> banks_full=1, rd_bank_valid=1, rd_len=256; reads at addr 0, 17, 255 return 0, 17, 255 one cycle later with rd_data_valid=1 and rd_oob=0.
- Stream 5 words with wr_last on the 5th -> rd_len=5; read addr 4 returns word 4 with rd_oob=0; read addr 5 gives rd_oob=1.
- Fill two blocks with the consumer idle -> banks_full=2, wr_ready=0; hold wr_valid=1, assert rd_release -> wr_ready=1 the next cycle, and the held word lands at bank 0, word 0.
- Complete a block in the same cycle as rd_release while banks_full=1 -> banks_full stays 1, rd_bank advances, and rd_len reflects the new head block.
- Assert rd_en and rd_release together -> read data comes from the released bank; a following read comes from the next bank. Then rd_en and rd_release with banks_full=0 -> no rd_data_valid and no state change.
- Deassert rst_n mid-block after 3 words -> all outputs return to reset values immediately; the next block starts at bank 0, word 0.
